// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and types for the codec audio receive path.
//   AUDIO_DATA_W      bits per captured channel word
//   AUDIO_SYNC_STAGES depth of the clk-domain input synchronisers
//   rx_state_e        receiver FSM states
//   LRCK_LEFT         ADCLRCK level that marks the left slot
package audio_pkg;

    localparam int AUDIO_DATA_W      = 16;
    localparam int AUDIO_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } rx_state_e;

    localparam logic LRCK_LEFT = 1'b0;

endpackage

// File: rtl/i2s_sync.sv
// i2s_sync: multi-flop synchroniser for one asynchronous codec line, with
// single-cycle rise/fall strobes derived from the synchronised copy.
//   clk     system clock
//   rst     asynchronous active-high reset
//   d_i     asynchronous input
//   q_o     synchronised level
//   rise_o  one clk pulse when q_o goes 0 -> 1
//   fall_o  one clk pulse when q_o goes 1 -> 0
module i2s_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: receives the codec ADC I2S stream (codec is master), splits
// it into left/right words and hands complete stereo pairs to the consumer
// through a valid/ready register.
//   clk, rst          system clock, asynchronous active-high reset
//   en_i              receive enable (codec init done)
//   aud_bclk_i        codec BCLK (async)
//   aud_lrck_i        codec ADCLRCK (async), 0 = left slot
//   aud_dat_i         codec ADCDAT (async)
//   left_o, right_o   held stereo pair
//   valid_o, ready_i  pair handshake
//   overrun_o         sticky: complete pair dropped while one was held
//   short_err_o       sticky: slot ended with a partial word
//   clr_err_i         clears both sticky flags (a same-cycle set wins)
//
// state | meaning
// IDLE  | waiting for enable and an LRCK falling edge (start of a left slot)
// RUN   | aligned to frames, capturing slot bits on BCLK rises
module i2s_adc_rx #(
    parameter int DATA_W      = audio_pkg::AUDIO_DATA_W,
    parameter int SYNC_STAGES = audio_pkg::AUDIO_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              aud_bclk_i,
    input  logic              aud_lrck_i,
    input  logic              aud_dat_i,
    output logic [DATA_W-1:0] left_o,
    output logic [DATA_W-1:0] right_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    output logic              short_err_o,
    input  logic              clr_err_i
);
    import audio_pkg::*;

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic bclk_s, bclk_rise, lrck_s, dat_s;
    logic unused_bclk_fall, unused_lrck_rise, unused_lrck_fall;
    logic unused_dat_rise, unused_dat_fall;

    i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .rst(rst), .d_i(aud_bclk_i),
        .q_o(bclk_s), .rise_o(bclk_rise), .fall_o(unused_bclk_fall));

    i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(clk), .rst(rst), .d_i(aud_lrck_i),
        .q_o(lrck_s), .rise_o(unused_lrck_rise), .fall_o(unused_lrck_fall));

    i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_dat (
        .clk(clk), .rst(rst), .d_i(aud_dat_i),
        .q_o(dat_s), .rise_o(unused_dat_rise), .fall_o(unused_dat_fall));

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] pend_left_q, pend_left_d;
    logic [DATA_W-1:0] left_q, left_d, right_q, right_d;
    logic              lrck_last_q, lrck_last_d;
    logic              pend_q, pend_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              short_q, short_d;
    logic              pair_done, set_short, set_ovr;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        pend_left_d = pend_left_q;
        pend_d      = pend_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        short_d     = short_q;
        pair_done   = 1'b0;
        set_short   = 1'b0;
        set_ovr     = 1'b0;
        // Last sampled LRCK is tracked in every state so IDLE can spot the
        // 1->0 transition that opens a frame.
        lrck_last_d = bclk_rise ? lrck_s : lrck_last_q;

        case (state_q)
            IDLE: begin
                if (en_i && bclk_rise && (lrck_last_q != LRCK_LEFT) && (lrck_s == LRCK_LEFT)) begin
                    state_d  = RUN;
                    bitcnt_d = '0;
                    shift_d  = '0;
                end
            end
            RUN: begin
                if (!en_i) begin
                    state_d  = IDLE;
                    bitcnt_d = '0;
                    shift_d  = '0;
                    pend_d   = 1'b0;
                end else if (bclk_rise) begin
                    if (lrck_s != lrck_last_q) begin
                        // Slot boundary; the bit on this edge still belongs
                        // to the previous slot (I2S one-bit delay).
                        if ((bitcnt_q != '0) && (bitcnt_q < CNT_FULL)) begin
                            set_short = 1'b1;
                            if (lrck_last_q == LRCK_LEFT) pend_d = 1'b0;
                        end
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end else if (bitcnt_q < CNT_FULL) begin
                        shift_d  = {shift_q[DATA_W-2:0], dat_s};
                        bitcnt_d = bitcnt_q + 1'b1;
                        if (bitcnt_q == CNT_LAST) begin
                            if (lrck_s == LRCK_LEFT) begin
                                pend_left_d = shift_d;
                                pend_d      = 1'b1;
                            end else if (pend_q) begin
                                pair_done = 1'b1;
                                pend_d    = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && ready_i) valid_d = 1'b0;

        if (pair_done) begin
            if (!valid_q || ready_i) begin
                left_d  = pend_left_q;
                right_d = shift_d;
                valid_d = 1'b1;
            end else begin
                set_ovr = 1'b1;
            end
        end

        if (clr_err_i) begin
            overrun_d = 1'b0;
            short_d   = 1'b0;
        end
        if (set_ovr)   overrun_d = 1'b1;
        if (set_short) short_d   = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            pend_left_q <= '0;
            pend_q      <= 1'b0;
            lrck_last_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            pend_left_q <= pend_left_d;
            pend_q      <= pend_d;
            lrck_last_q <= lrck_last_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            short_q     <= short_d;
        end
    end

    assign left_o      = left_q;
    assign right_o     = right_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
    assign short_err_o = short_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: codec-master I2S stimulus (32-bit slots, ~3.07 MHz BCLK,
// random clk phase) against a frame-level model of which pairs must reach
// the consumer, plus directed flag and reset checks.
module tb_i2s_adc_rx;

    localparam int H = 163;

    logic        clk, rst, en_i, aud_bclk, aud_lrck, aud_dat;
    logic        ready_i, clr_err_i;
    logic [15:0] left_o, right_o;
    logic        valid_o, overrun_o, short_err_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    logic        rdy_rand, rdy_fixed;

    // frame-level model
    logic        m_aligned, m_pend, m_prev_lr, m_held, m_exp_short, m_exp_ovr;
    logic [15:0] m_pend_left;

    i2s_adc_rx dut (
        .clk(clk), .rst(rst), .en_i(en_i),
        .aud_bclk_i(aud_bclk), .aud_lrck_i(aud_lrck), .aud_dat_i(aud_dat),
        .left_o(left_o), .right_o(right_o), .valid_o(valid_o), .ready_i(ready_i),
        .overrun_o(overrun_o), .short_err_o(short_err_o), .clr_err_i(clr_err_i));

    initial begin
        clk = 1'b0;
        #($urandom_range(1, 19));
        forever #10 clk = ~clk;
    end

    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && valid_o && ready_i) got_q.push_back({left_o, right_o});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_aligned = 0; m_pend = 0; m_prev_lr = 0; m_held = 0;
        m_exp_short = 0; m_exp_ovr = 0; m_pend_left = '0;
    endtask

    task automatic deliver(input logic [31:0] p);
        if (!rdy_rand && !rdy_fixed) begin
            if (m_held) m_exp_ovr = 1;
            else begin
                m_held = 1;
                exp_q.push_back(p);
            end
        end else begin
            exp_q.push_back(p);
        end
    endtask

    task automatic set_en(input logic v);
        en_i = v;
        if (!v) begin
            m_aligned = 0;
            m_pend    = 0;
        end
    endtask

    // One slot of nbits BCLK periods; the first rise carries the slot
    // boundary, rises 1..16 carry the word MSB first, the rest are filler.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits, input int en_at);
        logic en_start;
        int   captured;
        en_start = en_i;
        for (int i = 0; i < nbits; i++) begin
            if (i == en_at) en_i = 1'b1;
            if (i == 0) en_start = en_i;
            aud_lrck = lr;
            aud_dat  = (i >= 1 && i <= 16) ? w[16-i] : 1'($urandom_range(0, 1));
            #H aud_bclk = 1'b1;
            #H aud_bclk = 1'b0;
        end
        if (!en_start) begin
            m_aligned = 0;
            m_pend    = 0;
        end else begin
            if (!m_aligned && m_prev_lr && !lr) m_aligned = 1;
            if (m_aligned) begin
                captured = (nbits - 1 > 16) ? 16 : nbits - 1;
                if (captured == 16) begin
                    if (!lr) begin
                        m_pend      = 1;
                        m_pend_left = w;
                    end else if (m_pend) begin
                        m_pend = 0;
                        deliver({m_pend_left, w});
                    end
                end else if (captured >= 1) begin
                    m_exp_short = 1;
                    if (!lr) m_pend = 0;
                end
            end
        end
        m_prev_lr = lr;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_slot(1'b0, l, 32, -1);
        send_slot(1'b1, r, 32, -1);
    endtask

    task automatic check_pairs(input string tag);
        int n;
        repeat (10) @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_pair%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1 clr_err_i = 1'b1;
        @(posedge clk); #1 clr_err_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; aud_bclk = 1'b0; aud_lrck = 1'b1; aud_dat = 1'b0;
        clr_err_i = 1'b0; rdy_rand = 1'b0; rdy_fixed = 1'b1;
        model_reset();
        #100;
        chk("rst_valid", valid_o, 0);
        chk("rst_left", left_o, 0);
        chk("rst_right", right_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_short", short_err_o, 0);
        rst = 1'b0;
        #57;

        // basic pair
        set_en(1'b1);
        send_slot(1'b1, 16'($urandom), 32, -1);
        send_frame(16'hA5C3, 16'h1234);
        check_pairs("basic");
        chk("basic_valid_low", valid_o, 0);
        chk("basic_overrun", overrun_o, 0);
        chk("basic_short", short_err_o, 0);

        // enable raised in the middle of a right slot
        set_en(1'b0);
        send_slot(1'b0, 16'($urandom), 32, -1);
        send_slot(1'b1, 16'hDEAD, 32, 8);
        send_frame(16'h1111, 16'h2222);
        check_pairs("late_en");

        // consumer stalled across two frames
        rdy_fixed = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(16'h0001, 16'h0002);
        send_frame(16'h0003, 16'h0004);
        repeat (4) @(negedge clk);
        chk("stall_valid", valid_o, 1);
        chk("stall_left", left_o, 16'h0001);
        chk("stall_right", right_o, 16'h0002);
        chk("stall_overrun", overrun_o, m_exp_ovr);
        clr_pulse();
        m_exp_ovr = 0;
        chk("stall_overrun_clr", overrun_o, m_exp_ovr);
        rdy_fixed = 1'b1;
        m_held    = 0;
        check_pairs("stall");

        // left slot cut short after 10 bits
        send_slot(1'b0, 16'($urandom), 11, -1);
        send_slot(1'b1, 16'h5555, 32, -1);
        send_frame(16'h7FFF, 16'h8000);
        chk("short_flag", short_err_o, m_exp_short);
        check_pairs("short");
        clr_pulse();
        m_exp_short = 0;
        chk("short_clr", short_err_o, m_exp_short);

        // full scale then random traffic with a random-ready consumer
        send_frame(16'h8000, 16'hFFFF);
        rdy_rand = 1'b1;
        for (int f = 0; f < 30; f++) send_frame(16'($urandom), 16'($urandom));
        rdy_rand = 1'b0;
        check_pairs("random");
        chk("random_overrun", overrun_o, m_exp_ovr);
        chk("random_short", short_err_o, m_exp_short);

        // reset in the middle of a left slot with a pair held
        rdy_fixed = 1'b0;
        repeat (3) @(negedge clk);
        send_frame(16'h0A0A, 16'h0B0B);
        send_slot(1'b0, 16'h7777, 6, -1);
        chk("pre_rst_valid", valid_o, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_left", left_o, 0);
        chk("mid_rst_right", right_o, 0);
        chk("mid_rst_short", short_err_o, 0);
        #40;
        rst = 1'b0;
        model_reset();
        got_q.delete();
        exp_q.delete();
        rdy_fixed = 1'b1;
        send_slot(1'b0, 16'($urandom), 26, -1);
        send_slot(1'b1, 16'($urandom), 32, -1);
        send_frame(16'h1357, 16'h2468);
        check_pairs("post_rst");
        chk("post_rst_overrun", overrun_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
